// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
//   Request/response bundle between the EX stage and the multi-cycle RV32M
//   multiply/divide sequencer.
//   master : pipeline side; drives start, flush, op, op_a, op_b and observes
//            stall, busy, done, result.
//   slave  : sequencer side; the reverse directions.
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, op, op_a, op_b,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, flush, op, op_a, op_b,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle RV32M multiply/divide sequencer sitting beside the EX-stage ALU.
//   One op is accepted from IDLE, iterated one radix-2 step per cycle in CALC
//   (shift-add multiply / restoring divide on operand magnitudes) and presented
//   for exactly one cycle in DONE. Divide-by-zero and signed overflow skip CALC.
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       muldiv_seq_if.slave:
//               start/flush/op/op_a/op_b in, stall/busy/done/result out
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_seq_if.slave   bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [CW-1:0]       counter_r;
    logic [2:0]          op_r;
    logic                neg_r;       // final result needs negation
    logic [XLEN:0]       hi_r;        // product high half (+carry) / partial remainder
    logic [XLEN-1:0]     lo_r;        // multiplier bits / dividend-quotient shifter
    logic [XLEN:0]       mcand_r;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]     result_r;

    logic                accept_s;
    logic                is_div_s;
    logic                a_signed_s;
    logic                b_signed_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic                b_zero_s;
    logic                ovf_s;
    logic                fast_s;
    logic [XLEN-1:0]     fast_res_s;
    logic                neg_s;

    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       shifted_s;
    logic [XLEN:0]       diff_s;
    logic                ge_s;
    logic [XLEN:0]       hi_nx_s;
    logic [XLEN-1:0]     lo_nx_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     div_val_s;
    logic [XLEN-1:0]     final_res_s;

    assign accept_s  = (state_r == S_IDLE) && bus.start && !bus.flush;
    assign bus.stall = accept_s || (state_r == S_CALC);
    assign bus.busy  = (state_r != S_IDLE);
    assign bus.done  = (state_r == S_DONE);
    assign bus.result = result_r;

    // Operand decode at accept: signedness, magnitudes and fast-path detection.
    always_comb begin
        is_div_s   = bus.op[2];
        // MUL low half is sign-agnostic, so it is computed unsigned.
        a_signed_s = is_div_s ? !bus.op[0] : ((bus.op[1:0] == 2'b01) || (bus.op[1:0] == 2'b10));
        b_signed_s = is_div_s ? !bus.op[0] : (bus.op[1:0] == 2'b01);
        a_neg_s    = a_signed_s && bus.op_a[XLEN-1];
        b_neg_s    = b_signed_s && bus.op_b[XLEN-1];
        // The most-negative value negates to itself, which is its correct unsigned magnitude.
        a_mag_s    = a_neg_s ? (-bus.op_a) : bus.op_a;
        b_mag_s    = b_neg_s ? (-bus.op_b) : bus.op_b;
        b_zero_s   = (bus.op_b == '0);
        ovf_s      = is_div_s && !bus.op[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op_b);
        fast_s     = is_div_s && (b_zero_s || ovf_s);
        if (bus.op[1]) begin
            fast_res_s = b_zero_s ? bus.op_a : '0;
        end else begin
            // Overflow quotient equals the dividend (most-negative value).
            fast_res_s = b_zero_s ? '1 : bus.op_a;
        end
        if (is_div_s && bus.op[1]) begin
            neg_s = a_neg_s;
        end else begin
            neg_s = a_neg_s ^ b_neg_s;
        end
    end

    // One radix-2 iteration plus sign correction of the value it produces.
    always_comb begin
        sum_s     = hi_r + (lo_r[0] ? mcand_r : '0);
        shifted_s = {hi_r[XLEN-1:0], lo_r[XLEN-1]};
        diff_s    = shifted_s - mcand_r;
        ge_s      = (shifted_s >= mcand_r);
        if (op_r[2]) begin
            hi_nx_s = ge_s ? diff_s : shifted_s;
            lo_nx_s = {lo_r[XLEN-2:0], ge_s};
        end else begin
            hi_nx_s = {1'b0, sum_s[XLEN:1]};
            lo_nx_s = {sum_s[0], lo_r[XLEN-1:1]};
        end
        prod_s     = {hi_nx_s[XLEN-1:0], lo_nx_s};
        prod_fix_s = neg_r ? (-prod_s) : prod_s;
        div_val_s  = op_r[1] ? hi_nx_s[XLEN-1:0] : lo_nx_s;
        if (op_r[2]) begin
            final_res_s = neg_r ? (-div_val_s) : div_val_s;
        end else if (op_r[1:0] == 2'b00) begin
            final_res_s = prod_fix_s[XLEN-1:0];
        end else begin
            final_res_s = prod_fix_s[2*XLEN-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; flush always wins and returns to IDLE.
    always_comb begin
        state_nx_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nx_s = fast_s ? S_DONE : S_CALC;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_nx_s = S_IDLE;
                end else if (counter_r == '0) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_CALC;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Datapath registers: operand capture, iteration and result update.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_r <= '0;
            op_r      <= 3'd0;
            neg_r     <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
            mcand_r   <= '0;
            result_r  <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r      <= bus.op;
                        neg_r     <= neg_s;
                        counter_r <= CW'(XLEN - 1);
                        hi_r      <= '0;
                        if (is_div_s) begin
                            lo_r    <= a_mag_s;
                            mcand_r <= {1'b0, b_mag_s};
                        end else begin
                            lo_r    <= b_mag_s;
                            mcand_r <= {1'b0, a_mag_s};
                        end
                        if (fast_s) begin
                            result_r <= fast_res_s;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        counter_r <= '0;
                    end else begin
                        hi_r      <= hi_nx_s;
                        lo_r      <= lo_nx_s;
                        counter_r <= counter_r - CW'(1);
                        if (counter_r == '0) begin
                            result_r <= final_res_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
